// File: rtl/add_result_collector.sv
// Collects N_SAMPLES adder sums into one frame of total, maximum and minimum.
// Two states: ACCUM takes samples, HOLD presents the frame until taken.
module add_result_collector #(
  parameter int N_SAMPLES = 4,
  parameter int IN_W      = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  input  logic            clr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W+3:0] sum_total,
  output logic [IN_W-1:0] max_val,
  output logic [IN_W-1:0] min_val,
  output logic [3:0]      count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [3:0] LAST = 4'(N_SAMPLES - 1);

  state_t          state_q;
  logic [IN_W+3:0] acc_q;
  logic [IN_W-1:0] max_q;
  logic [IN_W-1:0] min_q;
  logic [3:0]      count_q;

  logic            first;
  logic [IN_W+3:0] acc_d;
  logic [IN_W-1:0] max_d;
  logic [IN_W-1:0] min_d;

  // First sample of a frame loads max/min outright
  always_comb begin
    first = (count_q == 4'd0);
    acc_d = acc_q + {4'd0, in_data};
    max_d = max_q;
    min_d = min_q;
    if (first || in_data > max_q)
      max_d = in_data;
    if (first || in_data < min_q)
      min_d = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (clr) begin
            acc_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            count_q <= '0;
          end else if (in_valid) begin
            acc_q   <= acc_d;
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= count_q + 4'd1;
            if (count_q == LAST)
              state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            count_q <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign sum_total = acc_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign count     = count_q;

endmodule

// File: doc/add_result_collector.md
ADD_RESULT_COLLECTOR -- requirements
Module: add_result_collector

Interface
REQ-001 Parameter N_SAMPLES, default 4, number of sums per output frame, legal range 1..16.
REQ-002 Parameter IN_W, default 5, width of each input sum.
REQ-003 Port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1, upstream sum present on in_data.
REQ-006 Port in_data, input, IN_W, unsigned sum from the adder stage.
REQ-007 Port in_ready, output, 1, block accepts in_data this cycle.
REQ-008 Port clr, input, 1, synchronous abort of the current frame.
REQ-009 Port out_valid, output, 1, frame result present.
REQ-010 Port out_ready, input, 1, downstream accepts the frame.
REQ-011 Port sum_total, output, IN_W+4, sum of the frame's samples.
REQ-012 Port max_val, output, IN_W, largest sample in the frame.
REQ-013 Port min_val, output, IN_W, smallest sample in the frame.
REQ-014 Port count, output, 4, samples accepted so far in the current frame.

Function
REQ-015 States SHALL be ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); both flags are decoded from registered state only.
REQ-016 A sample is accepted when in_valid=1 and in_ready=1 on a rising edge.
REQ-017 On acceptance, acc <= acc+in_data, max <= larger of max and in_data, min <= smaller of min and in_data, count <= count+1.
REQ-018 The first sample of a frame loads max and min directly. Prior values do not participate.
REQ-019 The accumulator is IN_W+4 bits wide and cannot overflow: max 16*31=496 < 512. No saturation logic.
REQ-020 Accepting the N_SAMPLES-th sample moves the FSM to HOLD on the same edge. sum_total, max_val and min_val include that sample and are valid on the next cycle (latency 1 cycle from the last accept).
REQ-021 In HOLD, sum_total, max_val and min_val SHALL remain stable until the handshake.
REQ-022 In HOLD, when out_ready=1 on an edge, the frame is consumed: FSM -> ACCUM; acc, count, max and min cleared to 0.
REQ-023 The first sample of the next frame is accepted no earlier than the cycle after consumption.
REQ-024 In HOLD, in_data is ignored whatever the value of in_valid.
REQ-025 clr=1 in ACCUM clears acc, count, max and min on the edge; no frame is emitted. Any sample presented in that cycle is discarded.
REQ-026 clr=1 in HOLD has no effect; a completed frame is never dropped.
REQ-027 With N_SAMPLES=1, every accepted sample produces a frame: sum_total=max_val=min_val=in_data.
REQ-028 In ACCUM, sum_total, max_val and min_val reflect running values.

Reset
REQ-029 When rst=0, the block SHALL asynchronously enter ACCUM with acc, max, min and count at 0, sum_total=0, max_val=0, min_val=0, out_valid=0 and in_ready=1.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or pending frame; no output is emitted after release.
REQ-031 Operation resumes on the first rising edge after rst returns to 1.

Verification (N_SAMPLES=4 unless stated)
REQ-032 Accept 3, 30, 0, 17 back-to-back, out_ready=1 -> one cycle of out_valid with sum_total=50, max_val=30, min_val=0; in_ready high again the next cycle.
REQ-033 Accept 31 four times -> sum_total=124, max_val=31, min_val=31.
REQ-034 Complete frame 5, 6, 7, 8 with out_ready=0 for 5 cycles -> out_valid held 5 cycles, sum_total=26 stable, in_ready=0. Samples driven during HOLD are not counted. Release -> count=0.
REQ-035 Accept 9, 9, then clr=1 with in_valid=1 and in_data=4 -> count=0. Then accept 1, 2, 3, 4 -> sum_total=10, max_val=4, min_val=1.
REQ-036 Accept 10, 20, then assert rst low asynchronously between edges -> outputs 0 immediately. After release, 2, 2, 2, 2 -> sum_total=8.
REQ-037 N_SAMPLES=1, stream 7 then 12 with out_ready=1 -> two frames: sum_total 7 then 12, one idle cycle between accepts.
